// File: rtl/cache_trace_buf_if.sv
// cache_trace_buf_if: event snoop and debug read bus for cache_trace_buf
// rd_tstamp exists only when CACHE_TRACE_TSTAMP_EN is defined
interface cache_trace_buf_if #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STATE_W = 4,
    parameter int DEPTH   = 16
`ifdef CACHE_TRACE_TSTAMP_EN
    , parameter int TS_W  = 16
`endif
);
    localparam int IW = $clog2(DEPTH);
    localparam int WW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic               ev_valid;
    logic [STATE_W-1:0] ev_state;
    logic [NUM_CH-1:0]  ev_way;
    logic [ADDR_W-1:0]  ev_addr;
    logic [DATA_W-1:0]  ev_data;
    logic               rd_en;
    logic [IW-1:0]      rd_idx;
    logic               rd_valid;
    logic               rd_err;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic [STATE_W-1:0] rd_state;
    logic [WW-1:0]      rd_way;
    logic               rd_hit;
    logic               rd_multi;
`ifdef CACHE_TRACE_TSTAMP_EN
    logic [TS_W-1:0]    rd_tstamp;
`endif
    modport master (
        output ev_valid, ev_state, ev_way, ev_addr, ev_data, rd_en, rd_idx,
        input  rd_valid, rd_err, rd_addr, rd_data, rd_state, rd_way, rd_hit, rd_multi
`ifdef CACHE_TRACE_TSTAMP_EN
        , input rd_tstamp
`endif
    );
    modport slave (
        input  ev_valid, ev_state, ev_way, ev_addr, ev_data, rd_en, rd_idx,
        output rd_valid, rd_err, rd_addr, rd_data, rd_state, rd_way, rd_hit, rd_multi
`ifdef CACHE_TRACE_TSTAMP_EN
        , output rd_tstamp
`endif
    );
endinterface

// File: rtl/cache_trace_buf.sv
// cache_trace_buf: circular cache-event trace with state-match trigger and registered debug read
// define CACHE_TRACE_TSTAMP_EN to store a free-running cycle stamp per entry
module cache_trace_buf #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STATE_W = 4,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_en,
    input  logic [STATE_W-1:0]       trig_state,
    input  logic [$clog2(DEPTH)-1:0] post_cnt,
    input  logic [NUM_CH-1:0]        way_mask,
    output logic [1:0]               tb_state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped,
    output logic [$clog2(DEPTH)-1:0] trig_idx,
    cache_trace_buf_if.slave         bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int WW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_cfg
        $error("cache_trace_buf: DEPTH must be a power of two >= 2 and TS_W >= 1");
    end
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
    typedef struct packed {
        logic [STATE_W-1:0] st;
        logic [WW-1:0]      way;
        logic               hit;
        logic               multi;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
`ifdef CACHE_TRACE_TSTAMP_EN
        logic [TS_W-1:0]    ts;
`endif
    } entry_t;
    state_t        state, nxt;
    entry_t        mem [DEPTH];
    entry_t        ent, rd_q;
    logic [IW-1:0] wr_ptr, remaining, phys;
    logic          acc, trig_hit, full, clr, wr, set_trig, rd_err_c;
`ifdef CACHE_TRACE_TSTAMP_EN
    logic [TS_W-1:0] ts;
`endif
    assign acc      = bus.ev_valid & (bus.ev_way == '0 | |(bus.ev_way & way_mask));
    assign trig_hit = acc & trig_en & (bus.ev_state == trig_state);
    assign full     = count == (IW+1)'(DEPTH);
    assign phys     = (wrapped ? wr_ptr : '0) + bus.rd_idx;
    assign rd_err_c = {1'b0, bus.rd_idx} >= count;
    assign tb_state = state;
    always_comb begin
        ent       = '0;
        ent.st    = bus.ev_state;
        ent.hit   = |bus.ev_way;
        ent.multi = $countones(bus.ev_way) > 1;
        ent.addr  = bus.ev_addr;
        ent.data  = bus.ev_data;
`ifdef CACHE_TRACE_TSTAMP_EN
        ent.ts    = ts;
`endif
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (bus.ev_way[i]) ent.way = WW'(i);
    end
    always_comb begin
        nxt      = state;
        clr      = 1'b0;
        wr       = 1'b0;
        set_trig = 1'b0;
        if (abort) nxt = IDLE;
        else if (arm) begin
            nxt = ARMED;
            clr = 1'b1;
        end else if (state == ARMED && acc) begin
            wr       = 1'b1;
            set_trig = trig_hit;
            nxt      = !trig_hit ? ARMED : post_cnt == '0 ? DONE : POST;
        end else if (state == POST && acc) begin
            wr  = 1'b1;
            nxt = remaining == IW'(1) ? DONE : POST;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
            trig_idx  <= '0;
            remaining <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
            rd_q      <= '0;
`ifdef CACHE_TRACE_TSTAMP_EN
            ts        <= '0;
`endif
        end else begin
            state <= nxt;
            if (clr) begin
                wr_ptr   <= '0;
                count    <= '0;
                wrapped  <= 1'b0;
                trig_idx <= '0;
            end else if (wr) begin
                wr_ptr  <= wr_ptr + 1'b1;
                count   <= full ? count : count + 1'b1;
                wrapped <= wrapped | full;
                if (set_trig) trig_idx <= full ? IW'(DEPTH - 1) : count[IW-1:0];
                else if (state == POST && full) trig_idx <= trig_idx == '0 ? '0 : trig_idx - 1'b1;
            end
            if (set_trig) remaining <= post_cnt;
            else if (wr && state == POST) remaining <= remaining - 1'b1;
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_err <= rd_err_c;
                rd_q       <= rd_err_c ? '0 : mem[phys];
            end
`ifdef CACHE_TRACE_TSTAMP_EN
            ts <= clr ? '0 : ts + 1'b1;
`endif
        end
    end
    always_ff @(posedge clk) if (wr) mem[wr_ptr] <= ent;
    assign bus.rd_addr  = rd_q.addr;
    assign bus.rd_data  = rd_q.data;
    assign bus.rd_state = rd_q.st;
    assign bus.rd_way   = rd_q.way;
    assign bus.rd_hit   = rd_q.hit;
    assign bus.rd_multi = rd_q.multi;
`ifdef CACHE_TRACE_TSTAMP_EN
    assign bus.rd_tstamp = rd_q.ts;
`endif
endmodule

// File: doc/cache_trace_buf.md
Name: cache_trace_buf

Overview:
- Synthesizable, parametrised event-trace recorder for the cache controller; replaces the fixed, simulation-only probe wires.
- Snoops the FSM state, one-hot way-hit, address and data on each cache event and stores them in a circular buffer of DEPTH entries.
- Freezes capture a programmable number of events after a state-match trigger.
- Captured entries are read back through a registered debug read port by the testbench or a debug bus.

Parameters:
NUM_CH, 4, number of ways (width of the one-hot way vector)
ADDR_W, 32, event address width
DATA_W, 32, event data width (one word)
STATE_W, 4, FSM state encoding width
DEPTH, 16, trace entries; power of two, >= 2
TS_W, 16, timestamp width (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
arm  in  1  pulse: clear the buffer and start capture
abort  in  1  pulse: return to IDLE from any state
trig_en  in  1  enable state-match trigger
trig_state  in  STATE_W  trigger state value
post_cnt  in  clog2(DEPTH)  events recorded after the trigger event
way_mask  in  NUM_CH  way filter
ev_valid  in  1  event strobe
ev_state  in  STATE_W  FSM state
ev_way  in  NUM_CH  one-hot way hit; 0 = miss
ev_addr  in  ADDR_W  event address
ev_data  in  DATA_W  event data
tb_state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE
count  out  clog2(DEPTH)+1  valid entries, saturates at DEPTH
wrapped  out  1  buffer has overwritten an entry
trig_idx  out  clog2(DEPTH)  logical index of the trigger entry
rd_en  in  1  read request
rd_idx  in  clog2(DEPTH)  logical index; 0 = oldest
rd_valid  out  1  read response strobe
rd_err  out  1  rd_idx >= count
rd_addr  out  ADDR_W  stored address
rd_data  out  DATA_W  stored data
rd_state  out  STATE_W  stored state
rd_way  out  clog2(NUM_CH)  encoded way
rd_hit  out  1  stored ev_way was non-zero
rd_multi  out  1  stored ev_way had more than one bit set

Behaviour:
- Reset:
  - tb_state=IDLE.
  - wr_ptr, count, wrapped, trig_idx and all rd_* outputs are 0.
  - Buffer contents are not reset.
- Acceptance: acc = ev_valid & (ev_way==0 | |(ev_way & way_mask)). Only accepted events are recorded, in ARMED and POST only.
- Write path:
  - Entry written at wr_ptr.
  - wr_ptr increments mod DEPTH.
  - count increments and saturates at DEPTH.
  - wrapped is set when a write lands while count==DEPTH.
- Way encode:
  - rd_way is the lowest set bit index.
  - rd_multi = popcount > 1.
  - rd_hit = |ev_way.
- FSM:
  - IDLE/DONE --arm--> ARMED; wr_ptr, count, wrapped and trig_idx are cleared that cycle and no event is recorded in that cycle.
  - ARMED --(acc & trig_en & ev_state==trig_state)--> the trigger event is recorded and trig_idx latches its logical index (count before the write if not full, else DEPTH-1).
    - If post_cnt==0: next state DONE.
    - Otherwise: next state POST with remaining=post_cnt.
  - POST: each accepted event is recorded and decrements remaining; the event that takes remaining to 0 is recorded, then the next state is DONE.
  - DONE: no writes; the buffer is frozen until arm.
  - abort in any state: next state IDLE; buffer and count are retained; abort has priority over arm and events.
  - arm in ARMED or POST restarts capture (same clearing as from IDLE).
  - arm and ev_valid in the same cycle: arm wins and the event is dropped.
- trig_idx tracking: in POST, when a write overwrites the oldest entry (wrapped condition), trig_idx decrements so it stays a logical index. If the trigger entry itself is overwritten (post_cnt >= DEPTH is impossible by width), trig_idx saturates at 0.
- Read:
  - One-cycle latency: rd_en in cycle N gives rd_valid=1 in cycle N+1.
  - Physical index = (wrapped ? wr_ptr : 0) + rd_idx mod DEPTH.
  - If rd_idx >= count: rd_err=1 and all rd_ field outputs are 0.
  - Reads are allowed in any state; a read of the slot being written in the same cycle returns the old contents.
- rd_valid is a single-cycle pulse; the rd_ field outputs hold their value until the next read.
- Reset asserted mid-capture: returns to IDLE immediately (asynchronous).

Optional Feature:
CACHE_TRACE_TSTAMP_EN
- Defined:
  - A TS_W-bit free-running cycle counter is added; it resets to 0 and wraps.
  - The counter is cleared on arm.
  - Each entry stores the counter value, presented on an extra output rd_tstamp (out, TS_W) with the same timing as rd_addr.
- Not defined: no counter, no storage and no rd_tstamp port.

Test Plan:
- Reset, arm, then 5 accepted events with addr 0x100..0x104 and no trigger → count=5, wrapped=0; rd_idx=0 returns addr 0x100, rd_idx=5 gives rd_err=1.
- Arm, then 20 events addr 0..19 with DEPTH=16 → count=16, wrapped=1; rd_idx=0 returns addr 4 and rd_idx=15 returns addr 19.
- Arm, trig_state=READ, post_cnt=3; the trigger arrives on event 7 → after events 8,9,10 tb_state=DONE; trig_idx=6; a further event 11 is not recorded (count=10).
- way_mask=4'b0010, events with ev_way 0001, 0010, 0000 and 0110 → only the last three are recorded; the entry for 0110 reads rd_way=1, rd_multi=1, rd_hit=1.
- arm coincident with ev_valid, then abort during POST → the coincident event is dropped; abort gives tb_state=IDLE with count retained, and a following trigger-state event is not recorded.
- With CACHE_TRACE_TSTAMP_EN: events at cycles 2 and 7 after arm → rd_tstamp values differ by 5.
